// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter,
// plus the mux select lines that steer the shared mux_4bit datapath.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0;
  logic       s1;
  logic       busy;

  modport master (output req, input gnt, input s0, input s1, input busy);
  modport slave  (input req, output gnt, output s0, output s1, output busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux_4bit among 4 requesters; {s1,s0} = granted index.
// Optional hold limit (forced release after MAX_HOLD cycles) under `define MUX_ARB_HOLD_LIMIT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate from ptr when any req is high
// GRANT | one owner holds gnt; released when its req drops (or hold limit hits)
module mux4_rr_arbiter #(
  parameter int Tpd      = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux4_rr_arbiter_if.slave    bus
);

  if (Tpd < 0 || MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_param
    $error("mux4_rr_arbiter: Tpd must be >= 0 and MAX_HOLD within 1..15");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic [3:0] gnt_q;
  logic       busy_q;
  logic [1:0] pick;
  logic [1:0] off;
  logic       release_now;

  // Scan from the farthest offset back to ptr so the closest requester wins.
  always_comb begin
    pick = ptr;
    off  = ptr;
    for (int k = 3; k >= 0; k--) begin
      off = ptr + 2'(k);
      if (bus.req[off]) pick = off;
    end
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [3:0] hold_cnt;
  logic       others_pending;

  assign others_pending = |(bus.req & ~gnt_q);
  assign release_now    = !bus.req[sel] ||
                          ((hold_cnt == 4'(MAX_HOLD)) && others_pending);
`else
  assign release_now    = !bus.req[sel];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      gnt_q    <= 4'b0000;
      busy_q   <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // sel is left alone while idle so the mux path stays on the last owner
          if (|bus.req) begin
            state    <= GRANT;
            gnt_q    <= 4'b0001 << pick;
            sel      <= pick;
            busy_q   <= 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt <= 4'd1;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            state  <= IDLE;
            gnt_q  <= 4'b0000;
            busy_q <= 1'b0;
            ptr    <= sel + 2'd1;
          end
`ifdef MUX_ARB_HOLD_LIMIT_EN
          else if (hold_cnt != 4'd15) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= 4'b0000;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.s0   = sel[0];
  assign bus.s1   = sel[1];
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, latency, rotation, ptr wrap,
// async reset mid-grant and hold behaviour (with or without the hold limit).
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.Tpd(1), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
    chk({tag, ".gnt"},  {4'b0, bus.gnt}, {4'b0, g});
    chk({tag, ".sel"},  {6'b0, bus.s1, bus.s0}, {6'b0, s});
    chk({tag, ".busy"}, {7'b0, bus.busy}, {7'b0, b});
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    chk_out("rst_pulse", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset with all requests high
    bus.req = 4'b1111;
    #2;
    chk_out("t1_rst", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("t1_rst_edge", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("t1_first", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_out("t1_rel", 4'b0000, 2'd0, 1'b0);

    // 2: single requester 2, then release leaves ptr=3
    rst_pulse();
    bus.req = 4'b0100;
    tick();
    chk_out("t2_gnt", 4'b0100, 2'd2, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk_out("t2_rel", 4'b0000, 2'd2, 1'b0);
    tick();
    chk_out("t2_idle", 4'b0000, 2'd2, 1'b0);
    bus.req = 4'b1111;
    tick();
    chk_out("t2_ptr3", 4'b1000, 2'd3, 1'b1);

    // 4: owner 3 drops while 0 raises -> dead cycle, then wrap to 0
    bus.req = 4'b0001;
    tick();
    chk_out("t4_dead", 4'b0000, 2'd3, 1'b0);
    tick();
    chk_out("t4_wrap", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0000;
    tick();

    // 3: rotation 0,1,2,3,0 with all requests high
    rst_pulse();
    bus.req = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk_out($sformatf("t3_g%0d", e), 4'b0001 << (e % 4), 2'(e % 4), 1'b1);
      tick();
      chk_out($sformatf("t3_h%0d", e), 4'b0001 << (e % 4), 2'(e % 4), 1'b1);
      bus.req[e % 4] = 1'b0;
      tick();
      chk_out($sformatf("t3_d%0d", e), 4'b0000, 2'(e % 4), 1'b0);
      bus.req[e % 4] = 1'b1;
    end
    bus.req = 4'b0000;
    tick();

    // 5: async reset mid-grant
    rst_pulse();
    bus.req = 4'b0010;
    tick();
    chk_out("t5_gnt", 4'b0010, 2'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("t5_async", 4'b0000, 2'd0, 1'b0);
    #1;
    rst = 1'b0;
    bus.req = 4'b1111;
    tick();
    chk_out("t5_ptr0", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0000;
    tick();

    // 6: hold behaviour with another requester pending
    rst_pulse();
    bus.req = 4'b0011;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out($sformatf("t6_hold%0d", c), 4'b0001, 2'd0, 1'b1);
    end
    tick();
    chk_out("t6_forced", 4'b0000, 2'd0, 1'b0);
    tick();
    chk_out("t6_next", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b0001;
    tick();
    chk_out("t6_dead2", 4'b0000, 2'd1, 1'b0);
    tick();
    chk_out("t6_solo", 4'b0001, 2'd0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk_out($sformatf("t6_solo%0d", c), 4'b0001, 2'd0, 1'b1);
    end
`else
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_out($sformatf("t6_hold%0d", c), 4'b0001, 2'd0, 1'b1);
    end
`endif
    bus.req = 4'b0000;
    tick();
    chk_out("t6_end", 4'b0000, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
